// File: rtl/led_step_ctrl.sv
// LED chaser step controller: three debounced pushbuttons set speed,
// direction and pause; a period counter emits one-cycle step strobes
// for a downstream LED shifter.
module led_step_ctrl #(
  parameter logic [24:0] DEB_MAX  = 25'd999_999,
  parameter logic [25:0] PERIOD_0 = 26'd49_999_999,
  parameter logic [25:0] PERIOD_1 = 26'd24_999_999,
  parameter logic [25:0] PERIOD_2 = 26'd12_499_999,
  parameter logic [25:0] PERIOD_3 = 26'd6_249_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_speed,
  input  logic       key_dir,
  input  logic       key_pause,
  output logic       step_pulse,
  output logic       step_dir,
  output logic [1:0] speed_sel,
  output logic       paused
);

  // bit 0 = speed, bit 1 = direction, bit 2 = pause
  logic [2:0]  key_raw;
  logic [2:0]  sync_1;
  logic [2:0]  sync_2;
  logic [2:0]  stable;
  logic [2:0]  stable_d;
  logic [2:0]  press;
  logic [25:0] step_cnt;
  logic [25:0] pmax;
  logic        running;

  assign key_raw = {key_pause, key_dir, key_speed};

  // Two-flop synchronizers; idle (released) level is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1 <= 3'b111;
      sync_2 <= 3'b111;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic        stab;
    logic [24:0] cnt;

    // Accept a new level only after it has differed for DEB_MAX+1 cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        stab <= 1'b1;
        cnt  <= '0;
      end else if (sync_2[i] == stab) begin
        cnt <= '0;
      end else if (cnt == DEB_MAX) begin
        stab <= sync_2[i];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 25'd1;
      end
    end

    assign stable[i] = stab;
  end

  // Delayed stable levels for falling-edge (press) detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) stable_d <= 3'b111;
    else            stable_d <= stable;
  end

  // Press pulse lasts the single cycle after stable falls; releases are ignored.
  assign press = stable_d & ~stable;

  // Mode registers; simultaneous presses all apply in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      speed_sel <= 2'b00;
      step_dir  <= 1'b0;
      paused    <= 1'b0;
    end else begin
      speed_sel <= speed_sel + {1'b0, press[0]};
      step_dir  <= step_dir ^ press[1];
      paused    <= paused ^ press[2];
    end
  end

  // Period limit for the current speed.
  always_comb begin
    pmax = PERIOD_0;
    case (speed_sel)
      2'd0:    pmax = PERIOD_0;
      2'd1:    pmax = PERIOD_1;
      2'd2:    pmax = PERIOD_2;
      default: pmax = PERIOD_3;
    endcase
  end

  // A pause press freezes the counter in the same cycle it lands, so the
  // held value is the count at the press; a resume press restarts at once.
  assign running = ~(paused ^ press[2]);

  // Step counter: speed press restarts the period, out-of-range values recover.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_cnt <= '0;
    end else if (press[0]) begin
      step_cnt <= '0;
    end else if (step_cnt > pmax) begin
      step_cnt <= '0;
    end else if (running) begin
      step_cnt <= (step_cnt == pmax) ? 26'd0 : step_cnt + 26'd1;
    end
  end

  // Registered strobe for the cycle after the counter reaches its limit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) step_pulse <= 1'b0;
    else            step_pulse <= running & ~press[0] & (step_cnt == pmax);
  end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl with small periods; a cycle-level behavioural
// model predicts every output from the raw key waveforms.
module tb_led_step_ctrl;

  localparam int DEB = 3;
  localparam int PER [4] = '{15, 7, 3, 1};

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] keys = 3'b111;
  logic       step_pulse, step_dir, paused;
  logic [1:0] speed_sel;

  led_step_ctrl #(
    .DEB_MAX (25'd3),
    .PERIOD_0(26'd15),
    .PERIOD_1(26'd7),
    .PERIOD_2(26'd3),
    .PERIOD_3(26'd1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_speed (keys[0]),
    .key_dir   (keys[1]),
    .key_pause (keys[2]),
    .step_pulse(step_pulse),
    .step_dir  (step_dir),
    .speed_sel (speed_sel),
    .paused    (paused)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model state
  int m_speed, m_phase;
  bit m_dir, m_paused, m_pulse;
  bit m_pend [3];
  bit m_stab [3];
  int m_since[3];
  bit m_hist [3][$];

  function automatic void model_reset();
    m_speed = 0; m_phase = 0; m_dir = 0; m_paused = 0; m_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_stab[k] = 1; m_since[k] = 0;
      m_hist[k].delete();
      for (int j = 0; j < 8; j++) m_hist[k].push_back(1'b1);
    end
  endfunction

  // One clock edge: apply pending presses, then see which keys settle.
  function automatic void model_step();
    bit sp, dp, pp, run, differ;
    int pmax;
    sp = m_pend[0]; dp = m_pend[1]; pp = m_pend[2];
    run  = !(m_paused ^ pp);
    pmax = PER[m_speed];
    m_pulse = run && (m_phase == pmax) && !sp;
    if (sp)       m_phase = 0;
    else if (run) m_phase = (m_phase == pmax) ? 0 : m_phase + 1;
    m_speed  = (m_speed + sp) % 4;
    m_dir    = m_dir ^ dp;
    m_paused = m_paused ^ pp;
    for (int k = 0; k < 3; k++) begin
      m_hist[k].push_front(keys[k]);
      if (m_hist[k].size() > 8) void'(m_hist[k].pop_back());
      m_since[k]++;
      m_pend[k] = 0;
      // synchronized level at this edge is the raw sample from two edges back
      differ = 1;
      for (int j = 2; j <= 2 + DEB; j++)
        if (m_hist[k][j] == m_stab[k]) differ = 0;
      if (differ && m_since[k] >= DEB + 1) begin
        if (m_stab[k]) m_pend[k] = 1;
        m_stab[k]  = !m_stab[k];
        m_since[k] = 0;
      end
    end
  endfunction

  int cyc, first_pulse;

  task automatic tick();
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else            model_step();
    #1;
    chk("step_pulse", step_pulse, m_pulse);
    chk("step_dir",   step_dir,   m_dir);
    chk("speed_sel",  speed_sel,  m_speed);
    chk("paused",     paused,     m_paused);
    cyc++;
    if (step_pulse && first_pulse < 0) first_pulse = cyc;
  endtask

  task automatic press_key(input int k, input int len);
    keys[k] = 1'b0;
    repeat (len) tick();
    keys[k] = 1'b1;
    repeat (20) tick();
  endtask

  task automatic check_first_pulse(input string tag);
    cyc = 0; first_pulse = -1;
    repeat (50) tick();
    chk(tag, first_pulse, PER[0] + 1);
  endtask

  int npulse, gap;
  int left [3];

  initial begin
    model_reset();
    repeat (2) tick();
    chk("rst_pulse", step_pulse, 0);
    chk("rst_speed", speed_sel, 0);
    sys_rst_n = 1'b1;
    check_first_pulse("first_pulse");

    // speed press landing exactly on the terminal count: no strobe, restart
    for (int i = 0; i < 40 && m_phase != 9; i++) tick();
    keys[0] = 1'b0;
    gap = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) keys[0] = 1'b1;
      tick();
      if (step_pulse && gap < 0) gap = i;
    end
    chk("coincide_gap", gap, 15);

    // three more speed presses wrap back to 0
    repeat (3) press_key(0, 10);
    chk("speed_wrap", speed_sel, 0);

    // direction glitch ignored, clean press toggles once
    press_key(1, 2);
    chk("dir_glitch", step_dir, 0);
    press_key(1, 10);
    chk("dir_press", step_dir, 1);

    // pause freezes stepping
    press_key(2, 10);
    chk("paused_set", paused, 1);
    npulse = 0;
    repeat (100) begin tick(); npulse += step_pulse; end
    chk("pause_quiet", npulse, 0);
    press_key(2, 10);
    chk("paused_clr", paused, 0);

    // randomized key activity
    for (int k = 0; k < 3; k++) left[k] = $urandom_range(5, 60);
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        if (left[k] == 0) begin
          keys[k] = ~keys[k];
          left[k] = keys[k] ? ((k == 0) ? $urandom_range(40, 150) : $urandom_range(20, 100))
                            : $urandom_range(1, 12);
        end else begin
          left[k]--;
        end
      end
      tick();
    end
    keys = 3'b111;
    repeat (20) tick();

    // drive to speed 3, direction 1, paused, then reset mid-period
    for (int i = 0; i < 4 && m_speed != 3; i++) press_key(0, 10);
    if (!m_dir) press_key(1, 10);
    if (!m_paused) press_key(2, 10);
    chk("pre_rst_speed", speed_sel, 3);
    chk("pre_rst_state", {step_dir, paused}, 3);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("async_pulse", step_pulse, 0);
    chk("async_dir",   step_dir,   0);
    chk("async_speed", speed_sel,  0);
    chk("async_pause", paused,     0);
    model_reset();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    check_first_pulse("first_pulse_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
